// File: rtl/nasti_stream_pkg.sv
// Shared constants, FSM state type and burst sizing helper for the NASTI
// memory-to-stream read engine.
package nasti_stream_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam int ID_WIDTH   = 4;
    localparam int DEST_WIDTH = 4;
    localparam int USER_WIDTH = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest of: beats left, max burst length, beats before the next 4 KB page.
    function automatic logic [8:0] burst_beats(
        input logic [11:0]  addr_lo,
        input logic [63:0]  remaining,
        input logic [8:0]   max_beats,
        input int unsigned  shift
    );
        logic [63:0] page;
        logic [63:0] lim;
        page = 64'((13'h1000 - {1'b0, addr_lo}) >> shift);
        lim  = {55'd0, max_beats};
        lim  = (page < lim) ? page : lim;
        lim  = (remaining < lim) ? remaining : lim;
        return 9'(lim);
    endfunction

endpackage

// File: rtl/nasti_burst_splitter.sv
// Walks a beat-aligned read range, issuing one AR burst at a time that never
// crosses a 4 KB page and never exceeds the maximum burst length.
module nasti_burst_splitter
    import nasti_stream_pkg::*;
#(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_BURST_LENGTH = 8,
    localparam int SHIFT           = $clog2(DATA_WIDTH / 8),
    localparam int CNT_W           = ADDR_WIDTH - SHIFT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [CNT_W-1:0]      beats,
    input  logic                  credit_ok,
    input  logic                  ar_ready,
    output logic                  ar_valid,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]            ar_len,
    output logic                  issue_done
);

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [CNT_W-1:0]      remaining_r;
    logic                  ar_valid_r;
    logic [ADDR_WIDTH-1:0] ar_addr_r;
    logic [7:0]            ar_len_r;
    logic [8:0]            next_beats_s;
    logic [CNT_W-1:0]      sent_beats_s;
    logic [ADDR_WIDTH-1:0] sent_bytes_s;

    // Size of the next burst and the span of the burst currently on AR.
    always_comb begin
        next_beats_s = burst_beats(addr_r[11:0], 64'(remaining_r),
                                   9'(MAX_BURST_LENGTH), SHIFT);
        sent_beats_s = CNT_W'({1'b0, ar_len_r}) + CNT_W'(1);
        sent_bytes_s = ADDR_WIDTH'(sent_beats_s) << SHIFT;
    end

    // Range cursor and AR holding register; AR fields stay frozen until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r      <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            ar_valid_r  <= 1'b0;
            ar_addr_r   <= {ADDR_WIDTH{1'b0}};
            ar_len_r    <= 8'd0;
        end else if (start) begin
            addr_r      <= addr;
            remaining_r <= beats;
            ar_valid_r  <= 1'b0;
        end else if (ar_valid_r) begin
            if (ar_ready) begin
                ar_valid_r  <= 1'b0;
                addr_r      <= addr_r + sent_bytes_s;
                remaining_r <= remaining_r - sent_beats_s;
            end
        end else if ((remaining_r != {CNT_W{1'b0}}) && credit_ok) begin
            ar_valid_r <= 1'b1;
            ar_addr_r  <= addr_r;
            ar_len_r   <= 8'(next_beats_s - 9'd1);
        end
    end

    assign ar_valid   = ar_valid_r;
    assign ar_addr    = ar_addr_r;
    assign ar_len     = ar_len_r;
    assign issue_done = (remaining_r == {CNT_W{1'b0}}) && !ar_valid_r;

endmodule

// File: rtl/nasti_stream_reader_chk.sv
// Protocol checks for the stream reader: request alignment, R-channel sanity
// against issued bursts, outstanding limit and address wrap.
module nasti_stream_reader_chk #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  req_valid,
    input logic                  req_ready,
    input logic [ADDR_WIDTH-1:0] req_src,
    input logic [ADDR_WIDTH-1:0] req_len,
    input logic                  ar_valid,
    input logic                  ar_ready,
    input logic [ADDR_WIDTH-1:0] ar_addr,
    input logic [7:0]            ar_len,
    input logic                  r_valid,
    input logic                  r_ready,
    input logic                  r_last,
    input logic [3:0]            outstanding
);
    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

    logic [7:0]          len_q_r [8];
    logic [2:0]          wr_ptr_r;
    logic [2:0]          rd_ptr_r;
    logic [7:0]          beat_r;
    logic                ar_hs_s;
    logic                r_hs_s;
    logic [ADDR_WIDTH:0] burst_end_s;

    assign ar_hs_s     = ar_valid && ar_ready;
    assign r_hs_s      = r_valid && r_ready;
    assign burst_end_s = {1'b0, ar_addr}
                       + (((ADDR_WIDTH + 1)'(ar_len) + (ADDR_WIDTH + 1)'(1)) << SHIFT);

    // Burst length FIFO written on AR handshake.
    always_ff @(posedge clk) begin
        if (ar_hs_s) begin
            len_q_r[wr_ptr_r] <= ar_len;
        end
    end

    // FIFO pointers and beat position within the burst being returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            beat_r   <= 8'd0;
        end else begin
            if (ar_hs_s) begin
                wr_ptr_r <= wr_ptr_r + 3'd1;
            end
            if (r_hs_s) begin
                if (r_last) begin
                    rd_ptr_r <= rd_ptr_r + 3'd1;
                    beat_r   <= 8'd0;
                end else begin
                    beat_r <= beat_r + 8'd1;
                end
            end
        end
    end

    a_len_aligned: assert property (@(posedge clk) disable iff (rst)
        (req_valid && req_ready) |-> ((req_len & LOW_MASK) == {ADDR_WIDTH{1'b0}}));
    a_src_aligned: assert property (@(posedge clk) disable iff (rst)
        (req_valid && req_ready) |-> ((req_src & LOW_MASK) == {ADDR_WIDTH{1'b0}}));
    a_no_stray_r: assert property (@(posedge clk) disable iff (rst)
        r_valid |-> (outstanding != 4'd0));
    a_burst_end: assert property (@(posedge clk) disable iff (rst)
        r_hs_s |-> (r_last == (beat_r == len_q_r[rd_ptr_r])));
    a_outstanding: assert property (@(posedge clk) disable iff (rst)
        outstanding <= 4'(MAX_OUTSTANDING));
    a_no_wrap: assert property (@(posedge clk) disable iff (rst)
        ar_hs_s |-> (!burst_end_s[ADDR_WIDTH] || (burst_end_s[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b0}})));

endmodule

// File: rtl/nasti_stream_reader.sv
// Memory-to-stream DMA read engine: splits a byte range into NASTI read bursts,
// keeps several in flight and forwards read data onto a NASTI stream.
module nasti_stream_reader
    import nasti_stream_pkg::*;
#(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_BURST_LENGTH = 8,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                    aclk,
    input  logic                    areset,
    output logic [ID_WIDTH-1:0]     src_ar_id,
    output logic [ADDR_WIDTH-1:0]   src_ar_addr,
    output logic [7:0]              src_ar_len,
    output logic [2:0]              src_ar_size,
    output logic [1:0]              src_ar_burst,
    output logic                    src_ar_lock,
    output logic [3:0]              src_ar_cache,
    output logic [2:0]              src_ar_prot,
    output logic                    src_ar_valid,
    input  logic                    src_ar_ready,
    input  logic [DATA_WIDTH-1:0]   src_r_data,
    input  logic [1:0]              src_r_resp,
    input  logic                    src_r_last,
    input  logic                    src_r_valid,
    output logic                    src_r_ready,
    output logic                    src_aw_valid,
    output logic                    src_w_valid,
    output logic                    src_b_ready,
    output logic [DATA_WIDTH-1:0]   dest_t_data,
    output logic [DATA_WIDTH/8-1:0] dest_t_strb,
    output logic [DATA_WIDTH/8-1:0] dest_t_keep,
    output logic                    dest_t_last,
    output logic [ID_WIDTH-1:0]     dest_t_id,
    output logic [DEST_WIDTH-1:0]   dest_t_dest,
    output logic [USER_WIDTH-1:0]   dest_t_user,
    output logic                    dest_t_valid,
    input  logic                    dest_t_ready,
    input  logic [ADDR_WIDTH-1:0]   r_src,
    input  logic [ADDR_WIDTH-1:0]   r_len,
    input  logic                    r_valid,
    output logic                    r_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int CNT_W = ADDR_WIDTH - SHIFT;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] deliver_r;
    logic [3:0]       outstanding_r;
    logic             err_r;
    logic             accept_s;
    logic             t_hs_s;
    logic             last_hs_s;
    logic             ar_hs_s;
    logic             r_last_hs_s;
    logic             credit_ok_s;
    logic             issue_done_s;
    logic [CNT_W-1:0] len_beats_s;

    assign accept_s    = r_valid && (state_r != RUN);
    assign len_beats_s = CNT_W'(r_len >> SHIFT);
    assign t_hs_s      = src_r_valid && dest_t_ready;
    assign last_hs_s   = t_hs_s && (deliver_r == CNT_W'(1));
    assign ar_hs_s     = src_ar_valid && src_ar_ready;
    assign r_last_hs_s = t_hs_s && src_r_last;
    assign credit_ok_s = outstanding_r < 4'(MAX_OUTSTANDING);

    nasti_burst_splitter #(
        .ADDR_WIDTH       (ADDR_WIDTH),
        .DATA_WIDTH       (DATA_WIDTH),
        .MAX_BURST_LENGTH (MAX_BURST_LENGTH)
    ) u_splitter (
        .clk        (aclk),
        .rst        (areset),
        .start      (accept_s),
        .addr       (r_src & ALIGN_MASK),
        .beats      (len_beats_s),
        .credit_ok  (credit_ok_s),
        .ar_ready   (src_ar_ready),
        .ar_valid   (src_ar_valid),
        .ar_addr    (src_ar_addr),
        .ar_len     (src_ar_len),
        .issue_done (issue_done_s)
    );

    // Next-state logic: a zero-length request completes without touching the bus.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    if (len_beats_s == {CNT_W{1'b0}}) state_s = DONE;
                    else                              state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_hs_s && issue_done_s) state_s = DONE;
                else                           state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Delivery countdown, sticky error and in-flight burst count.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            deliver_r     <= {CNT_W{1'b0}};
            outstanding_r <= 4'd0;
            err_r         <= 1'b0;
        end else begin
            if (accept_s) begin
                deliver_r <= len_beats_s;
                err_r     <= 1'b0;
            end else if ((state_r == RUN) && t_hs_s) begin
                deliver_r <= deliver_r - CNT_W'(1);
                if ((src_r_resp == RESP_SLVERR) || (src_r_resp == RESP_DECERR)) begin
                    err_r <= 1'b1;
                end
            end
            case ({ar_hs_s, r_last_hs_s})
                2'b10:   outstanding_r <= outstanding_r + 4'd1;
                2'b01:   outstanding_r <= outstanding_r - 4'd1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign src_ar_id    = {ID_WIDTH{1'b0}};
    assign src_ar_size  = 3'(SHIFT);
    assign src_ar_burst = BURST_INCR;
    assign src_ar_lock  = 1'b0;
    assign src_ar_cache = 4'd0;
    assign src_ar_prot  = 3'd0;
    assign src_aw_valid = 1'b0;
    assign src_w_valid  = 1'b0;
    assign src_b_ready  = 1'b0;

    // Read data streams straight through; burst r_last is replaced by the transfer end.
    assign dest_t_valid = src_r_valid;
    assign dest_t_data  = src_r_data;
    assign src_r_ready  = dest_t_ready;
    assign dest_t_last  = (deliver_r == CNT_W'(1));
    assign dest_t_strb  = {(DATA_WIDTH/8){1'b1}};
    assign dest_t_keep  = {(DATA_WIDTH/8){1'b1}};
    assign dest_t_id    = {ID_WIDTH{1'b0}};
    assign dest_t_dest  = {DEST_WIDTH{1'b0}};
    assign dest_t_user  = {USER_WIDTH{1'b0}};

    assign r_ready = (state_r != RUN);
    assign busy    = (state_r == RUN);
    assign done    = (state_r == DONE);
    assign err     = err_r;

    nasti_stream_reader_chk #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_chk (
        .clk         (aclk),
        .rst         (areset),
        .req_valid   (r_valid),
        .req_ready   (r_ready),
        .req_src     (r_src),
        .req_len     (r_len),
        .ar_valid    (src_ar_valid),
        .ar_ready    (src_ar_ready),
        .ar_addr     (src_ar_addr),
        .ar_len      (src_ar_len),
        .r_valid     (src_r_valid),
        .r_ready     (src_r_ready),
        .r_last      (src_r_last),
        .outstanding (outstanding_r)
    );

endmodule

// File: tb/tb_nasti_stream_reader.sv
// Directed bench for nasti_stream_reader with a small NASTI read slave whose
// data word is a tag ORed with the beat's byte address.
module tb_nasti_stream_reader;
    import nasti_stream_pkg::*;

    localparam logic [63:0] TAG = 64'hA500_0000_0000_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  src_ar_id;
    logic [63:0] src_ar_addr;
    logic [7:0]  src_ar_len;
    logic [2:0]  src_ar_size;
    logic [1:0]  src_ar_burst;
    logic        src_ar_lock;
    logic [3:0]  src_ar_cache;
    logic [2:0]  src_ar_prot;
    logic        src_ar_valid;
    logic        src_ar_ready;
    logic [63:0] src_r_data;
    logic [1:0]  src_r_resp;
    logic        src_r_last;
    logic        src_r_valid;
    logic        src_r_ready;
    logic        src_aw_valid, src_w_valid, src_b_ready;
    logic [63:0] dest_t_data;
    logic [7:0]  dest_t_strb, dest_t_keep;
    logic        dest_t_last;
    logic [3:0]  dest_t_id, dest_t_dest;
    logic [0:0]  dest_t_user;
    logic        dest_t_valid;
    logic        dest_t_ready;
    logic [63:0] r_src, r_len;
    logic        r_valid, r_ready, busy, done, err;

    int total = 0;
    int bad   = 0;

    logic [63:0] q_addr[$];
    int          q_len[$];
    logic [63:0] ar_addr_log[$];
    int          ar_len_log[$];
    logic [63:0] beat_data[$];
    bit          beat_last[$];
    logic [63:0] cur_addr;
    int          cur_left;
    bit          cur_active;
    bit          r_en;
    bit          tmode;
    int          r_hs_cnt;
    int          err_beat;

    nasti_stream_reader dut (
        .aclk(aclk), .areset(areset),
        .src_ar_id(src_ar_id), .src_ar_addr(src_ar_addr), .src_ar_len(src_ar_len),
        .src_ar_size(src_ar_size), .src_ar_burst(src_ar_burst), .src_ar_lock(src_ar_lock),
        .src_ar_cache(src_ar_cache), .src_ar_prot(src_ar_prot),
        .src_ar_valid(src_ar_valid), .src_ar_ready(src_ar_ready),
        .src_r_data(src_r_data), .src_r_resp(src_r_resp), .src_r_last(src_r_last),
        .src_r_valid(src_r_valid), .src_r_ready(src_r_ready),
        .src_aw_valid(src_aw_valid), .src_w_valid(src_w_valid), .src_b_ready(src_b_ready),
        .dest_t_data(dest_t_data), .dest_t_strb(dest_t_strb), .dest_t_keep(dest_t_keep),
        .dest_t_last(dest_t_last), .dest_t_id(dest_t_id), .dest_t_dest(dest_t_dest),
        .dest_t_user(dest_t_user), .dest_t_valid(dest_t_valid), .dest_t_ready(dest_t_ready),
        .r_src(r_src), .r_len(r_len), .r_valid(r_valid), .r_ready(r_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 aclk = ~aclk;

    // Read slave and stream logger: drive on the falling edge, observe handshakes just before the rise.
    always begin
        @(negedge aclk);
        if (!cur_active && q_addr.size() > 0) begin
            cur_addr   = q_addr.pop_front();
            cur_left   = q_len.pop_front() + 1;
            cur_active = 1'b1;
        end
        src_r_valid  = r_en && cur_active && !areset;
        src_r_data   = TAG | cur_addr;
        src_r_last   = cur_active && (cur_left == 1);
        src_r_resp   = (r_hs_cnt == err_beat) ? 2'b10 : 2'b00;
        dest_t_ready = tmode ? ~dest_t_ready : 1'b1;
        #4;
        if (areset) begin
            q_addr.delete();
            q_len.delete();
            cur_active = 1'b0;
        end else begin
            if (src_ar_valid && src_ar_ready) begin
                q_addr.push_back(src_ar_addr);
                q_len.push_back(int'(src_ar_len));
                ar_addr_log.push_back(src_ar_addr);
                ar_len_log.push_back(int'(src_ar_len));
            end
            if (dest_t_valid && dest_t_ready) begin
                beat_data.push_back(dest_t_data);
                beat_last.push_back(dest_t_last);
            end
            if (src_r_valid && src_r_ready) begin
                r_hs_cnt++;
                cur_addr = cur_addr + 64'd8;
                cur_left--;
                if (cur_left == 0) cur_active = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        ar_addr_log.delete();
        ar_len_log.delete();
        beat_data.delete();
        beat_last.delete();
        r_hs_cnt = 0;
    endtask

    task automatic start_req(input logic [63:0] src, input logic [63:0] len);
        @(negedge aclk);
        r_src   = src;
        r_len   = len;
        r_valid = 1'b1;
        @(negedge aclk);
        r_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output bit rdy);
        seen = 1'b0;
        rdy  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge aclk);
            #2;
            if (done) begin
                seen = 1'b1;
                rdy  = r_ready;
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        #2;
        total++; if ({r_ready, busy, done, err} !== 4'b1000) begin bad++; $display("FAIL reset_status: got %b want 1000", {r_ready, busy, done, err}); end
        total++; if ({src_ar_valid, src_aw_valid, src_w_valid, src_b_ready} !== 4'b0000) begin bad++; $display("FAIL reset_valids: got %b want 0000", {src_ar_valid, src_aw_valid, src_w_valid, src_b_ready}); end
        total++; if ({src_ar_size, src_ar_burst} !== 5'b011_01) begin bad++; $display("FAIL ar_consts: got %b want 01101", {src_ar_size, src_ar_burst}); end
        total++; if ({dest_t_strb, dest_t_keep} !== 16'hFFFF) begin bad++; $display("FAIL strb_keep: got %h want ffff", {dest_t_strb, dest_t_keep}); end
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_single_burst();
        bit seen, rdy;
        clear_logs();
        start_req(64'h1000, 64'h40);
        wait_done(100, seen, rdy);
        total++; if (!seen || !rdy) begin bad++; $display("FAIL t1_done: got seen=%0d r_ready=%0d want 1 1", seen, rdy); end
        total++; if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 64'h1000 || ar_len_log[0] != 7) begin bad++; $display("FAIL t1_ar: got n=%0d addr=%h want n=1 addr=1000 len=7", ar_addr_log.size(), ar_addr_log[0]); end
        total++; if (beat_data.size() != 8) begin bad++; $display("FAIL t1_beats: got %0d want 8", beat_data.size()); end
        for (int i = 0; i < beat_data.size(); i++) begin
            total++; if (beat_data[i] !== (TAG | (64'h1000 + 64'(i * 8))) || beat_last[i] != (i == 7)) begin bad++; $display("FAIL t1_beat%0d: got %h last=%0d", i, beat_data[i], beat_last[i]); end
        end
        @(negedge aclk);
        #2;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_outstanding();
        bit seen, rdy;
        int lasts;
        clear_logs();
        r_en = 1'b0;
        start_req(64'h1000, 64'h100);
        repeat (10) @(negedge aclk);
        #2;
        total++; if (ar_addr_log.size() != 2 || src_ar_valid !== 1'b0) begin bad++; $display("FAIL t2_limit: got n=%0d ar_valid=%b want 2 0", ar_addr_log.size(), src_ar_valid); end
        total++; if (ar_addr_log.size() >= 2 && (ar_addr_log[0] !== 64'h1000 || ar_addr_log[1] !== 64'h1040)) begin bad++; $display("FAIL t2_first_addrs: got %h %h want 1000 1040", ar_addr_log[0], ar_addr_log[1]); end
        r_en = 1'b1;
        wait_done(300, seen, rdy);
        total++; if (!seen) begin bad++; $display("FAIL t2_done: got 0 want 1"); end
        total++; if (ar_addr_log.size() != 4 || ar_addr_log[2] !== 64'h1080 || ar_addr_log[3] !== 64'h10C0) begin bad++; $display("FAIL t2_ars: got n=%0d want 4 (1080,10c0 last)", ar_addr_log.size()); end
        lasts = 0;
        for (int i = 0; i < beat_data.size(); i++) begin
            if (beat_last[i]) lasts++;
            if (beat_data[i] !== (TAG | (64'h1000 + 64'(i * 8)))) begin total++; bad++; $display("FAIL t2_data%0d: got %h", i, beat_data[i]); end
        end
        total++; if (beat_data.size() != 32 || lasts != 1 || !beat_last[beat_data.size() - 1]) begin bad++; $display("FAIL t2_stream: got beats=%0d lasts=%0d want 32 1", beat_data.size(), lasts); end
    endtask

    task automatic test_page_split();
        bit seen, rdy;
        clear_logs();
        start_req(64'h1FE0, 64'h40);
        wait_done(100, seen, rdy);
        total++; if (!seen) begin bad++; $display("FAIL t3_done: got 0 want 1"); end
        total++; if (ar_addr_log.size() != 2 || ar_addr_log[0] !== 64'h1FE0 || ar_len_log[0] != 3 || ar_addr_log[1] !== 64'h2000 || ar_len_log[1] != 3) begin bad++; $display("FAIL t3_ars: got n=%0d %h/%0d want 1fe0/3 2000/3", ar_addr_log.size(), ar_addr_log[0], ar_len_log[0]); end
        total++; if (beat_data.size() != 8) begin bad++; $display("FAIL t3_beats: got %0d want 8", beat_data.size()); end
        for (int i = 0; i < beat_data.size(); i++) begin
            total++; if (beat_data[i] !== (TAG | (64'h1FE0 + 64'(i * 8))) || beat_last[i] != (i == 7)) begin bad++; $display("FAIL t3_beat%0d: got %h last=%0d", i, beat_data[i], beat_last[i]); end
        end
    endtask

    task automatic test_zero_length();
        clear_logs();
        start_req(64'h3000, 64'h0);
        #2;
        total++; if ({done, r_ready, busy} !== 3'b110) begin bad++; $display("FAIL t4_done: got %b want 110", {done, r_ready, busy}); end
        @(negedge aclk);
        #2;
        total++; if (done !== 1'b0 || ar_addr_log.size() != 0 || beat_data.size() != 0) begin bad++; $display("FAIL t4_quiet: got done=%b ars=%0d beats=%0d want 0 0 0", done, ar_addr_log.size(), beat_data.size()); end
    endtask

    task automatic test_error();
        bit seen, rdy;
        clear_logs();
        err_beat = 2;
        start_req(64'h1000, 64'h40);
        wait_done(100, seen, rdy);
        err_beat = -1;
        total++; if (!seen || err !== 1'b1) begin bad++; $display("FAIL t5_err_set: got seen=%0d err=%b want 1 1", seen, err); end
        total++; if (beat_data.size() != 8 || !beat_last[beat_data.size() - 1]) begin bad++; $display("FAIL t5_beats: got %0d want 8", beat_data.size()); end
        repeat (2) @(negedge aclk);
        #2;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL t5_sticky: got %b want 1", err); end
        clear_logs();
        start_req(64'h2000, 64'h40);
        #2;
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL t5_clear: got err=%b busy=%b want 0 1", err, busy); end
        wait_done(100, seen, rdy);
        total++; if (!seen || err !== 1'b0) begin bad++; $display("FAIL t5_clean_run: got seen=%0d err=%b want 1 0", seen, err); end
    endtask

    task automatic test_reset_abort();
        bit seen, rdy;
        clear_logs();
        tmode = 1'b1;
        start_req(64'h1000, 64'h100);
        for (int i = 0; i < 200 && beat_data.size() < 5; i++) @(negedge aclk);
        total++; if (beat_data.size() < 5) begin bad++; $display("FAIL t6_progress: got %0d beats want >=5", beat_data.size()); end
        @(negedge aclk);
        areset = 1'b1;
        #2;
        total++; if ({src_ar_valid, r_ready, busy, done} !== 4'b0100) begin bad++; $display("FAIL t6_abort: got %b want 0100", {src_ar_valid, r_ready, busy, done}); end
        @(negedge aclk);
        areset = 1'b0;
        tmode  = 1'b0;
        clear_logs();
        start_req(64'h1000, 64'h40);
        wait_done(100, seen, rdy);
        total++; if (!seen || !rdy || err !== 1'b0) begin bad++; $display("FAIL t6_restart_done: got seen=%0d r_ready=%0d err=%b", seen, rdy, err); end
        total++; if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 64'h1000 || ar_len_log[0] != 7) begin bad++; $display("FAIL t6_ar: got n=%0d want 1 (1000/7)", ar_addr_log.size()); end
        total++; if (beat_data.size() != 8) begin bad++; $display("FAIL t6_beats: got %0d want 8", beat_data.size()); end
        for (int i = 0; i < beat_data.size(); i++) begin
            total++; if (beat_data[i] !== (TAG | (64'h1000 + 64'(i * 8))) || beat_last[i] != (i == 7)) begin bad++; $display("FAIL t6_beat%0d: got %h last=%0d", i, beat_data[i], beat_last[i]); end
        end
    endtask

    initial begin
        areset       = 1'b1;
        r_valid      = 1'b0;
        r_src        = 64'd0;
        r_len        = 64'd0;
        src_ar_ready = 1'b1;
        src_r_valid  = 1'b0;
        src_r_data   = 64'd0;
        src_r_resp   = 2'b00;
        src_r_last   = 1'b0;
        dest_t_ready = 1'b1;
        cur_active   = 1'b0;
        cur_addr     = 64'd0;
        cur_left     = 0;
        r_en         = 1'b1;
        tmode        = 1'b0;
        r_hs_cnt     = 0;
        err_beat     = -1;
        test_reset();
        test_single_burst();
        test_outstanding();
        test_page_split();
        test_zero_length();
        test_error();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
